// File: rtl/sat_enum_search.sv
// sat_enum_search
//   Brute-force search controller for a combinational circuit-SAT benchmark.
//   Walks every input assignment in ascending order, one per cycle. It samples
//   the benchmark's 'sat' output against the registered candidate. It reports
//   the first witness, or UNSAT once the space is exhausted, and can resume
//   after a hit to enumerate every solution.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   start_i       begin a search at assignment 0 (honoured in IDLE only)
//   abort_i       stop the running search and report an aborted result
//   assign_o      current candidate, wired to the benchmark inputs
//   sat_i         benchmark output for assign_o (combinational, same cycle)
//   busy_o        search in progress
//   res_valid_o   result available; held until res_ready_i
//   res_ready_i   consumer accepts the result
//   resume_i      sampled with the accept: continue after a SAT hit
//   res_sat_o     witness found (0 = UNSAT or aborted)
//   res_abort_o   result was produced by abort_i
//   res_wit_o     satisfying assignment (valid when res_sat_o)
//   res_cnt_o     candidates evaluated since start_i
module sat_enum_search #(
  parameter int unsigned N_IN  = 8,
  parameter int unsigned CNT_W = N_IN + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  output logic [N_IN-1:0]  assign_o,
  input  logic             sat_i,
  output logic             busy_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  input  logic             resume_i,
  output logic             res_sat_o,
  output logic             res_abort_o,
  output logic [N_IN-1:0]  res_wit_o,
  output logic [CNT_W-1:0] res_cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    REPORT
  } state_t;

  state_t           state, state_nxt;
  logic [N_IN-1:0]  cand, cand_nxt;
  logic [N_IN-1:0]  wit, wit_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rsat, rsat_nxt;
  logic             rabort, rabort_nxt;
  logic             cand_last;

  assign cand_last = &cand;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cand   <= '0;
      wit    <= '0;
      cnt    <= '0;
      rsat   <= 1'b0;
      rabort <= 1'b0;
    end else begin
      state  <= state_nxt;
      cand   <= cand_nxt;
      wit    <= wit_nxt;
      cnt    <= cnt_nxt;
      rsat   <= rsat_nxt;
      rabort <= rabort_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cand_nxt   = cand;
    wit_nxt    = wit;
    cnt_nxt    = cnt;
    rsat_nxt   = rsat;
    rabort_nxt = rabort;

    unique case (state)
      IDLE: begin
        if (start_i) begin
          cand_nxt   = '0;
          cnt_nxt    = '0;
          wit_nxt    = '0;
          rsat_nxt   = 1'b0;
          rabort_nxt = 1'b0;
          state_nxt  = SEARCH;
        end
      end

      SEARCH: begin
        if (abort_i) begin
          // The candidate on the bus this cycle is not counted.
          rabort_nxt = 1'b1;
          rsat_nxt   = 1'b0;
          state_nxt  = REPORT;
        end else if (sat_i) begin
          wit_nxt   = cand;
          rsat_nxt  = 1'b1;
          cnt_nxt   = cnt + CNT_W'(1);
          state_nxt = REPORT;
        end else if (cand_last) begin
          rsat_nxt  = 1'b0;
          cnt_nxt   = cnt + CNT_W'(1);
          state_nxt = REPORT;
        end else begin
          cand_nxt = cand + N_IN'(1);
          cnt_nxt  = cnt + CNT_W'(1);
        end
      end

      REPORT: begin
        if (res_ready_i) begin
          if (resume_i && rsat) begin
            rsat_nxt = 1'b0;
            // Resuming from the top assignment has nothing left to try:
            // stay here and present the closing UNSAT report instead.
            if (!cand_last) begin
              cand_nxt  = cand + N_IN'(1);
              state_nxt = SEARCH;
            end
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign assign_o    = cand;
  assign busy_o      = (state == SEARCH);
  assign res_valid_o = (state == REPORT);
  assign res_sat_o   = rsat;
  assign res_abort_o = rabort;
  assign res_wit_o   = wit;
  assign res_cnt_o   = cnt;

endmodule

// File: tb/tb_sat_enum_search.sv
// Bench for sat_enum_search (N_IN=8). The benchmark is replaced by selectable
// stub predicates; a transaction-level model predicts each search's outcome
// by scanning the predicate and is compared with the DUT on every falling edge.
module tb_sat_enum_search;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i, abort_i, sat_i, res_ready_i, resume_i;
  logic [7:0] assign_o, res_wit_o;
  logic [8:0] res_cnt_o;
  logic       busy_o, res_valid_o, res_sat_o, res_abort_o;

  int unsigned mode;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  always #5 clk = ~clk;

  sat_enum_search #(.N_IN(8), .CNT_W(9)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .assign_o(assign_o), .sat_i(sat_i), .busy_o(busy_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .resume_i(resume_i),
    .res_sat_o(res_sat_o), .res_abort_o(res_abort_o),
    .res_wit_o(res_wit_o), .res_cnt_o(res_cnt_o)
  );

  // Benchmark stubs: 0 never, 1 only 0x5A, 2 low two bits set,
  // 3 multiplier_37_sat with a=x[4:0], b=x[7:5] (37 is prime > 31: UNSAT).
  function automatic logic pred(int unsigned md, logic [7:0] x);
    int a, b;
    a = int'(x[4:0]);
    b = int'(x[7:5]);
    case (md)
      1: return x == 8'h5A;
      2: return x[1:0] == 2'b11;
      3: return (a * b) == 37;
      default: return 1'b0;
    endcase
  endfunction

  always_comb sat_i = pred(mode, assign_o);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // ph: 0 idle, 1 searching, 2 result pending
  int   ph, m_cand, m_cnt, m_rem, m_hit, e_wit;
  logic e_sat, e_abort;

  function automatic int first_hit(int from);
    for (int k = from; k < 256; k++)
      if (pred(mode, 8'(k))) return k;
    return 256;
  endfunction

  task automatic enter_search();
    m_hit = first_hit(m_cand);
    m_rem = (m_hit < 256) ? (m_hit - m_cand + 1) : (256 - m_cand);
    ph    = 1;
  endtask

  initial begin
    ph = 0; m_cand = 0; m_cnt = 0; e_wit = 0; e_sat = 0; e_abort = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        ph = 0; m_cand = 0; m_cnt = 0; e_wit = 0; e_sat = 0; e_abort = 0;
      end else begin
        case (ph)
          0: if (start_i) begin
               m_cand = 0; m_cnt = 0; e_wit = 0; e_sat = 0; e_abort = 0;
               enter_search();
             end
          1: if (abort_i) begin
               e_abort = 1; e_sat = 0; ph = 2;
             end else begin
               m_cnt++;
               if (m_rem == 1) begin
                 ph = 2;
                 e_sat = (m_hit < 256);
                 if (m_hit < 256) e_wit = m_hit;
               end else begin
                 m_cand++;
                 m_rem--;
               end
             end
          default: if (res_ready_i) begin
               if (resume_i && e_sat) begin
                 e_sat = 0;
                 if (m_cand != 255) begin
                   m_cand++;
                   enter_search();
                 end
               end else begin
                 ph = 0;
               end
             end
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        check("assign", assign_o, m_cand);
        check("busy", busy_o, ph == 1);
        check("valid", res_valid_o, ph == 2);
        check("res_sat", res_sat_o, e_sat);
        check("res_abort", res_abort_o, e_abort);
        check("res_wit", res_wit_o, e_wit);
        check("res_cnt", res_cnt_o, m_cnt);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_valid(input int maxc, input string tag);
    int n = 0;
    while (res_valid_o !== 1'b1 && n < maxc) begin
      step();
      n++;
    end
    if (res_valid_o !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got valid=%b after %0d cycles expected 1", tag, res_valid_o, n);
    end
  endtask

  task automatic accept(input logic r);
    res_ready_i = 1'b1;
    resume_i    = r;
    @(posedge clk);
    #1;
    res_ready_i = 1'b0;
    resume_i    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_i = 0; abort_i = 0; res_ready_i = 0; resume_i = 0;
    mode = 0; cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_assign", assign_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_valid", res_valid_o, 0);
    check("rst_sat", res_sat_o, 0);
    check("rst_abort", res_abort_o, 0);
    check("rst_wit", res_wit_o, 0);
    check("rst_cnt", res_cnt_o, 0);
    rst = 1'b0;
    step();

    // T1: multiplier_37 exhaustive UNSAT
    mode = 3;
    do_start();
    wait_valid(300, "t1");
    check("t1_latency", cyc, 257);
    check("t1_sat", res_sat_o, 0);
    check("t1_abort", res_abort_o, 0);
    check("t1_cnt", res_cnt_o, 256);
    accept(1'b0);

    // T2: single witness 0x5A
    mode = 1;
    do_start();
    wait_valid(300, "t2");
    check("t2_latency", cyc, 92);
    check("t2_sat", res_sat_o, 1);
    check("t2_wit", res_wit_o, 8'h5A);
    check("t2_cnt", res_cnt_o, 91);
    accept(1'b0);

    // T3: enumerate all 64 solutions, then closing UNSAT
    mode = 2;
    do_start();
    for (int i = 0; i < 64; i++) begin
      wait_valid(10, "t3");
      check("t3_wit", res_wit_o, 4 * i + 3);
      check("t3_sat", res_sat_o, 1);
      accept(1'b1);
    end
    wait_valid(3, "t3_end");
    check("t3_end_sat", res_sat_o, 0);
    check("t3_end_abort", res_abort_o, 0);
    check("t3_end_cnt", res_cnt_o, 256);
    accept(1'b0);

    // T4: abort on the 10th search cycle, result held with ready low
    mode = 0;
    do_start();
    repeat (9) step();
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    for (int j = 0; j < 5; j++) begin
      check("t4_valid", res_valid_o, 1);
      check("t4_abort", res_abort_o, 1);
      check("t4_sat", res_sat_o, 0);
      check("t4_cnt", res_cnt_o, 9);
      step();
    end
    accept(1'b0);

    // T5: asynchronous reset mid-search at candidate 0x40
    mode = 0;
    do_start();
    begin
      int n = 0;
      while (assign_o !== 8'h40 && n < 100) begin
        step();
        n++;
      end
      check("t5_reach40", assign_o, 8'h40);
    end
    #2;
    rst = 1'b1;
    #1;
    check("t5_assign", assign_o, 0);
    check("t5_busy", busy_o, 0);
    check("t5_cnt", res_cnt_o, 0);
    check("t5_valid", res_valid_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    do_start();
    check("t5_restart_assign", assign_o, 0);
    check("t5_restart_cnt", res_cnt_o, 0);
    step();
    check("t5_next_assign", assign_o, 1);
    check("t5_next_cnt", res_cnt_o, 1);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    accept(1'b0);

    // T6: start held high throughout
    mode = 1;
    start_i = 1'b1;
    step();
    cyc = 1;
    wait_valid(300, "t6");
    check("t6_sat", res_sat_o, 1);
    check("t6_wit", res_wit_o, 8'h5A);
    check("t6_cnt", res_cnt_o, 91);
    repeat (3) step();
    check("t6_hold_valid", res_valid_o, 1);
    accept(1'b0);
    check("t6_idle_busy", busy_o, 0);
    check("t6_idle_valid", res_valid_o, 0);
    step();
    check("t6_rerun_busy", busy_o, 1);
    check("t6_rerun_assign", assign_o, 0);
    check("t6_rerun_cnt", res_cnt_o, 0);
    start_i = 1'b0;
    wait_valid(300, "t6b");
    check("t6b_wit", res_wit_o, 8'h5A);
    accept(1'b0);
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
